// File: rtl/rv32i_pkg.sv
// Shared types for the issue-side register file controller.
package rv32i_pkg;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2
    } ctrl_state_e;

    localparam int NUM_WB = 2;

    // x0 is hardwired, so it never counts as busy.
    function automatic logic is_busy(input logic [31:0] busy, input reg_addr_t addr);
        return (addr != 5'd0) && busy[addr];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the grant is frozen while the caller holds lock.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       advance,
    output logic       grant,
    output logic       grant_valid
);

    logic rr_ptr;
    logic lock_q;
    logic grant_q;
    logic pick;

    always_comb begin
        pick = rr_ptr;
        if (!req[rr_ptr]) pick = ~rr_ptr;
        if (lock_q) begin
            grant       = grant_q;
            grant_valid = req[grant_q];
        end else begin
            grant       = pick;
            grant_valid = |req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr  <= 1'b0;
            lock_q  <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            lock_q  <= lock;
            grant_q <= grant;
            if (advance) rr_ptr <= ~grant;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Issue-side register file controller: busy scoreboard, operand read sequencing
// and round-robin arbitration of the single rd write port.
module regfile_access_ctrl
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_iss_valid,
    output logic                        o_iss_ready,
    input  reg_addr_t                   i_iss_rs1,
    input  reg_addr_t                   i_iss_rs2,
    input  reg_addr_t                   i_iss_rd,
    input  logic                        i_iss_rd_en,
    output logic                        o_rs1_arvalid,
    input  logic                        i_rs1_arready,
    output reg_addr_t                   o_rs1_araddr,
    input  logic [XLEN-1:0]             i_rs1_rdata,
    output logic                        o_rs2_arvalid,
    input  logic                        i_rs2_arready,
    output reg_addr_t                   o_rs2_araddr,
    input  logic [XLEN-1:0]             i_rs2_rdata,
    output logic                        o_op_valid,
    input  logic                        i_op_ready,
    output logic [XLEN-1:0]             o_op_rs1,
    output logic [XLEN-1:0]             o_op_rs2,
    input  logic [NUM_WB-1:0]           i_wb_valid,
    output logic [NUM_WB-1:0]           o_wb_ready,
    input  reg_addr_t [NUM_WB-1:0]      i_wb_addr,
    input  logic [NUM_WB-1:0][XLEN-1:0] i_wb_data,
    output logic                        o_rd_wvalid,
    input  logic                        i_rd_wready,
    output reg_addr_t                   o_rd_waddr,
    output logic [XLEN-1:0]             o_rd_wdata,
    output logic                        o_spurious_wb,
    output logic [31:0]                 o_busy,
    output ctrl_state_e                 o_state
);

    // Every channel transfers on the cycle where valid && ready are both high;
    // a valid, once raised, holds its payload stable until that cycle.
    ctrl_state_e     state_q, state_d;
    logic [31:0]     busy_q, busy_d;
    reg_addr_t       rs1_addr_q, rs2_addr_q;
    logic            rs1_pend_q, rs2_pend_q;
    logic [XLEN-1:0] op_rs1_q, op_rs2_q;
    logic            spur_q;
    logic            wb_grant, wb_gvalid;
    logic            iss_hs, rs1_hs, rs2_hs, wb_hs;

    assign iss_hs = i_iss_valid && o_iss_ready;
    assign rs1_hs = o_rs1_arvalid && i_rs1_arready;
    assign rs2_hs = o_rs2_arvalid && i_rs2_arready;
    assign wb_hs  = o_rd_wvalid && i_rd_wready;

    assign o_busy        = busy_q;
    assign o_state       = state_q;
    assign o_rs1_araddr  = rs1_addr_q;
    assign o_rs2_araddr  = rs2_addr_q;
    assign o_op_rs1      = op_rs1_q;
    assign o_op_rs2      = op_rs2_q;
    assign o_spurious_wb = spur_q;

    always_comb begin
        state_d       = state_q;
        o_iss_ready   = 1'b0;
        o_rs1_arvalid = 1'b0;
        o_rs2_arvalid = 1'b0;
        o_op_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                o_iss_ready = !is_busy(busy_q, i_iss_rs1) && !is_busy(busy_q, i_iss_rs2) &&
                              !(i_iss_rd_en && is_busy(busy_q, i_iss_rd));
                if (i_iss_valid && o_iss_ready) state_d = READ;
            end
            READ: begin
                o_rs1_arvalid = rs1_pend_q;
                o_rs2_arvalid = rs2_pend_q;
                if ((!rs1_pend_q || i_rs1_arready) && (!rs2_pend_q || i_rs2_arready))
                    state_d = OUT;
            end
            OUT: begin
                o_op_valid = 1'b1;
                if (i_op_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rstn        (rstn),
        .req         (i_wb_valid),
        .lock        (o_rd_wvalid && !i_rd_wready),
        .advance     (wb_hs),
        .grant       (wb_grant),
        .grant_valid (wb_gvalid)
    );

    // Write port outputs are zeroed when nothing is granted.
    always_comb begin
        o_rd_wvalid = wb_gvalid;
        o_rd_waddr  = 5'd0;
        o_rd_wdata  = '0;
        o_wb_ready  = '0;
        if (wb_gvalid) begin
            o_rd_waddr           = i_wb_addr[wb_grant];
            o_rd_wdata           = i_wb_data[wb_grant];
            o_wb_ready[wb_grant] = i_rd_wready;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_hs) busy_d[o_rd_waddr] = 1'b0;
        if (iss_hs && i_iss_rd_en) busy_d[i_iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            busy_q     <= '0;
            rs1_addr_q <= 5'd0;
            rs2_addr_q <= 5'd0;
            rs1_pend_q <= 1'b0;
            rs2_pend_q <= 1'b0;
            op_rs1_q   <= '0;
            op_rs2_q   <= '0;
            spur_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            spur_q  <= wb_hs && (o_rd_waddr != 5'd0) && !busy_q[o_rd_waddr];
            if (iss_hs) begin
                rs1_addr_q <= i_iss_rs1;
                rs2_addr_q <= i_iss_rs2;
                rs1_pend_q <= 1'b1;
                rs2_pend_q <= 1'b1;
            end
            if (rs1_hs) begin
                op_rs1_q   <= i_rs1_rdata;
                rs1_pend_q <= 1'b0;
            end
            if (rs2_hs) begin
                op_rs2_q   <= i_rs2_rdata;
                rs2_pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: arbitration table plus hand-written
// issue/read/writeback sequences.
module tb_regfile_access_ctrl;
    import rv32i_pkg::*;

    localparam int XLEN = 32;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   iss_valid = 1'b0, iss_ready, iss_rd_en = 1'b0;
    reg_addr_t              iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
    logic                   rs1_arvalid, rs2_arvalid;
    logic                   rs1_arready = 1'b0, rs2_arready = 1'b0;
    reg_addr_t              rs1_araddr, rs2_araddr;
    logic [XLEN-1:0]        rs1_rdata = '0, rs2_rdata = '0;
    logic                   op_valid, op_ready = 1'b0;
    logic [XLEN-1:0]        op_rs1, op_rs2;
    logic [1:0]             wb_valid = 2'b00, wb_ready;
    reg_addr_t [1:0]        wb_addr = '0;
    logic [1:0][XLEN-1:0]   wb_data = '0;
    logic                   rd_wvalid, rd_wready = 1'b0;
    reg_addr_t              rd_waddr;
    logic [XLEN-1:0]        rd_wdata;
    logic                   spurious_wb;
    logic [31:0]            busy;
    ctrl_state_e            state;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn),
        .i_iss_valid(iss_valid), .o_iss_ready(iss_ready),
        .i_iss_rs1(iss_rs1), .i_iss_rs2(iss_rs2), .i_iss_rd(iss_rd), .i_iss_rd_en(iss_rd_en),
        .o_rs1_arvalid(rs1_arvalid), .i_rs1_arready(rs1_arready),
        .o_rs1_araddr(rs1_araddr), .i_rs1_rdata(rs1_rdata),
        .o_rs2_arvalid(rs2_arvalid), .i_rs2_arready(rs2_arready),
        .o_rs2_araddr(rs2_araddr), .i_rs2_rdata(rs2_rdata),
        .o_op_valid(op_valid), .i_op_ready(op_ready),
        .o_op_rs1(op_rs1), .o_op_rs2(op_rs2),
        .i_wb_valid(wb_valid), .o_wb_ready(wb_ready),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_rd_wvalid(rd_wvalid), .i_rd_wready(rd_wready),
        .o_rd_waddr(rd_waddr), .o_rd_wdata(rd_wdata),
        .o_spurious_wb(spurious_wb), .o_busy(busy), .o_state(state)
    );

    typedef struct {
        logic [1:0]  valid;
        logic        wready;
        logic        exp_wvalid;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_ready;
    } arb_vec_t;

    arb_vec_t tbl[12];

    localparam logic [31:0] D0 = 32'hA0A0_0000;
    localparam logic [31:0] D1 = 32'hB1B1_0001;

    function automatic arb_vec_t av(input logic [1:0] v, input logic w, input int g,
                                    input logic [1:0] r);
        arb_vec_t x;
        x.valid      = v;
        x.wready     = w;
        x.exp_wvalid = (g >= 0);
        x.exp_addr   = (g == 0) ? 5'd10 : (g == 1) ? 5'd11 : 5'd0;
        x.exp_data   = (g == 0) ? D0 : (g == 1) ? D1 : 32'd0;
        x.exp_ready  = r;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        iss_valid = 1'b0; iss_rd_en = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
        rs1_arready = 1'b0; rs2_arready = 1'b0; rs1_rdata = '0; rs2_rdata = '0;
        op_ready = 1'b0; wb_valid = 2'b00; wb_addr = '0; wb_data = '0; rd_wready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic issue(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                         input logic rd_en);
        iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_en = rd_en;
    endtask

    initial begin
        tbl[0]  = av(2'b11, 1'b1, 0,  2'b01);
        tbl[1]  = av(2'b11, 1'b1, 1,  2'b10);
        tbl[2]  = av(2'b11, 1'b1, 0,  2'b01);
        tbl[3]  = av(2'b11, 1'b1, 1,  2'b10);
        tbl[4]  = av(2'b11, 1'b0, 0,  2'b00);
        tbl[5]  = av(2'b11, 1'b0, 0,  2'b00);
        tbl[6]  = av(2'b11, 1'b0, 0,  2'b00);
        tbl[7]  = av(2'b11, 1'b1, 0,  2'b01);
        tbl[8]  = av(2'b01, 1'b1, 0,  2'b01);
        tbl[9]  = av(2'b10, 1'b1, 1,  2'b10);
        tbl[10] = av(2'b10, 1'b1, 1,  2'b10);
        tbl[11] = av(2'b00, 1'b1, -1, 2'b00);

        // Reset values, then a basic issue with both reads accepted immediately.
        do_reset();
        #1;
        chk("rst_iss_ready", iss_ready, 1'b1);
        chk("rst_busy", busy, 32'd0);
        chk("rst_state", state, IDLE);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_arvalid", {rs1_arvalid, rs2_arvalid}, 2'b00);
        chk("rst_wvalid", rd_wvalid, 1'b0);
        chk("rst_wb_ready", wb_ready, 2'b00);
        chk("rst_spurious", spurious_wb, 1'b0);
        chk("rst_op_rs1", op_rs1, 32'd0);
        issue(5'd1, 5'd2, 5'd3, 1'b1);
        rs1_arready = 1'b1; rs2_arready = 1'b1;
        rs1_rdata = 32'h1111; rs2_rdata = 32'h2222;
        #1 chk("t1_iss_ready", iss_ready, 1'b1);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("t1_state_read", state, READ);
        chk("t1_arvalid", {rs1_arvalid, rs2_arvalid}, 2'b11);
        chk("t1_araddr", {rs1_araddr, rs2_araddr}, {5'd1, 5'd2});
        chk("t1_busy3", busy, 32'h8);
        chk("t1_op_valid_early", op_valid, 1'b0);
        tick();
        rs1_arready = 1'b0; rs2_arready = 1'b0;
        #1;
        chk("t1_op_valid", op_valid, 1'b1);
        chk("t1_op_rs1", op_rs1, 32'h1111);
        chk("t1_op_rs2", op_rs2, 32'h2222);
        tick();
        #1 chk("t1_op_valid_hold", op_valid, 1'b1);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        #1;
        chk("t1_state_idle", state, IDLE);
        chk("t1_busy_still", busy, 32'h8);
        wb_valid = 2'b10; wb_addr[1] = 5'd3; wb_data[1] = 32'h3333; rd_wready = 1'b1;
        #1;
        chk("t1_wb_ready", wb_ready, 2'b10);
        chk("t1_waddr", rd_waddr, 5'd3);
        tick();
        wb_valid = 2'b00;
        #1;
        chk("t1_busy_clear", busy, 32'd0);
        chk("t1_no_spurious", spurious_wb, 1'b0);

        // RAW stall on busy x5, released the cycle after the writeback.
        do_reset();
        rs1_arready = 1'b1; rs2_arready = 1'b1; op_ready = 1'b1;
        issue(5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        iss_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("t2_state_idle", state, IDLE);
        chk("t2_busy5", busy, 32'h20);
        issue(5'd5, 5'd0, 5'd6, 1'b1);
        #1 chk("t2_stall_a", iss_ready, 1'b0);
        tick();
        #1 chk("t2_stall_b", iss_ready, 1'b0);
        wb_valid = 2'b01; wb_addr[0] = 5'd5; rd_wready = 1'b1;
        #1;
        chk("t2_no_bypass", iss_ready, 1'b0);
        chk("t2_wb_ready", wb_ready, 2'b01);
        tick();
        wb_valid = 2'b00;
        #1 chk("t2_released", iss_ready, 1'b1);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("t2_state_read", state, READ);
        chk("t2_busy6", busy, 32'h40);

        // rd=x0 never becomes busy; writeback spurious detection.
        do_reset();
        rs1_arready = 1'b1; rs2_arready = 1'b1; op_ready = 1'b1;
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        iss_valid = 1'b0;
        #1 chk("t3_x0_not_busy", busy, 32'd0);
        tick();
        tick();
        issue(5'd0, 5'd0, 5'd4, 1'b1);
        #1 chk("t3_rs1_x0_ready", iss_ready, 1'b1);
        tick();
        iss_valid = 1'b0;
        #1 chk("t3_state_read", state, READ);
        tick();
        tick();
        wb_valid = 2'b01; wb_addr[0] = 5'd9; rd_wready = 1'b1;
        tick();
        wb_valid = 2'b00;
        #1 chk("t3_spurious_pulse", spurious_wb, 1'b1);
        wb_valid = 2'b10; wb_addr[1] = 5'd4;
        tick();
        wb_valid = 2'b00;
        #1;
        chk("t3_spurious_low", spurious_wb, 1'b0);
        chk("t3_busy4_cleared", busy, 32'd0);
        wb_valid = 2'b01; wb_addr[0] = 5'd0;
        tick();
        wb_valid = 2'b00;
        #1 chk("t3_x0_no_spurious", spurious_wb, 1'b0);

        // Round-robin arbitration and locking, table-driven.
        do_reset();
        wb_addr[0] = 5'd10; wb_addr[1] = 5'd11; wb_data[0] = D0; wb_data[1] = D1;
        for (int i = 0; i < 12; i++) begin
            wb_valid  = tbl[i].valid;
            rd_wready = tbl[i].wready;
            #1;
            chk($sformatf("arb%0d_wvalid", i), rd_wvalid, tbl[i].exp_wvalid);
            chk($sformatf("arb%0d_waddr", i), rd_waddr, tbl[i].exp_addr);
            chk($sformatf("arb%0d_wdata", i), rd_wdata, tbl[i].exp_data);
            chk($sformatf("arb%0d_wb_ready", i), wb_ready, tbl[i].exp_ready);
            tick();
        end
        wb_valid = 2'b00;

        // rs2 read delayed four cycles while rs1 is accepted immediately.
        do_reset();
        rs1_arready = 1'b1; rs2_arready = 1'b0;
        rs1_rdata = 32'h100; rs2_rdata = 32'hBAD0;
        issue(5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        iss_valid = 1'b0;
        #1 chk("t5_arvalid_r1", {rs1_arvalid, rs2_arvalid}, 2'b11);
        tick();
        rs1_rdata = 32'hDEAD;
        #1;
        chk("t5_arvalid_r2", {rs1_arvalid, rs2_arvalid}, 2'b01);
        chk("t5_state_r2", state, READ);
        tick();
        tick();
        tick();
        rs2_arready = 1'b1; rs2_rdata = 32'h200;
        #1 chk("t5_arvalid_r5", {rs1_arvalid, rs2_arvalid}, 2'b01);
        tick();
        rs2_arready = 1'b0; rs2_rdata = 32'hFFFF;
        #1;
        chk("t5_state_out", state, OUT);
        chk("t5_op_valid", op_valid, 1'b1);
        chk("t5_op_rs1", op_rs1, 32'h100);
        chk("t5_op_rs2", op_rs2, 32'h200);
        tick();
        #1 chk("t5_op_rs2_hold", op_rs2, 32'h200);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        // Reset while a read is outstanding drops everything.
        do_reset();
        rs1_arready = 1'b1; rs2_arready = 1'b1; op_ready = 1'b1;
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        iss_valid = 1'b0;
        tick();
        tick();
        rs1_arready = 1'b0; rs2_arready = 1'b0;
        issue(5'd1, 5'd2, 5'd7, 1'b1);
        tick();
        iss_valid = 1'b0;
        tick();
        #1;
        chk("t6_state_read", state, READ);
        chk("t6_busy_3_7", busy, 32'h88);
        rstn = 1'b0;
        tick();
        #1;
        chk("t6_state_idle", state, IDLE);
        chk("t6_busy_zero", busy, 32'd0);
        chk("t6_arvalid_zero", {rs1_arvalid, rs2_arvalid}, 2'b00);
        chk("t6_op_valid_zero", op_valid, 1'b0);
        chk("t6_wvalid_zero", rd_wvalid, 1'b0);
        chk("t6_iss_ready", iss_ready, 1'b1);
        rstn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
